// File: rtl/i2c_burst_master_pkg.sv
// Shared definitions for the burst I2C master: FSM states, SCL quarter
// indices and the bus-level ACK/NACK levels.
package i2c_burst_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_STOP
    } state_t;

    // Quarters of one SCL bit: Q0/Q1 SCL low, Q2/Q3 SCL high.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // SDA level during the ninth (acknowledge) bit.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [2:0] LAST_BIT = 3'd7;

    // SCL is pulled low during the first half of every bit.
    function automatic logic scl_low(input logic [1:0] q);
        return (q == Q0) || (q == Q1);
    endfunction

endpackage

// File: rtl/i2c_burst_master_if.sv
// Command, data and pad signals of the burst I2C master.
// master: the I2C master block; slave: command logic and pad side.
interface i2c_burst_master_if #(
    parameter int LEN_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_addr;
    logic             cmd_rw;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             nack;
    logic             scl_oe;
    logic             sda_oe;
    logic             sda_in;

    modport master (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_len, tx_data, sda_in,
        output cmd_ready, tx_ready, rx_data, rx_valid, busy, done, nack,
               scl_oe, sda_oe
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_rw, cmd_len, tx_data, sda_in,
        input  cmd_ready, tx_ready, rx_data, rx_valid, busy, done, nack,
               scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_burst_master_tick_gen.sv
// Quarter-period timebase for the I2C master. The counter only moves while
// enabled, so an idle link has no toggling registers.
module i2c_burst_master_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick,
    output logic [1:0] quarter,
    output logic       q_first
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick    = en && (cnt == CNT_MAX);
    assign q_first = (cnt == '0);

    // Divider and quarter index; wraps to zero at the end of each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            quarter <= 2'd0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt     <= '0;
                quarter <= quarter + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_burst_master.sv
// Burst I2C master: START, address + R/W, 0..MAX_BYTES data bytes, STOP.
// Pad outputs are decoded from the registered state and quarter index.
module i2c_burst_master
    import i2c_burst_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    i2c_burst_master_if.master  bus
);
    state_t           state, state_nxt;
    logic             tick, q_first;
    logic [1:0]       quarter;
    logic             bit_end, sample, accept, last_byte, wr_bit;
    logic             tx_ready_c, scl_oe_c, sda_oe_c;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt, len_q, len_clamped;
    logic             rw_q, ack_q, nack_flag;
    logic             done_q, nack_q, rx_valid_q;
    logic [7:0]       rx_data_q, shift;

    i2c_burst_master_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (reset),
        .en      (state != ST_IDLE),
        .tick    (tick),
        .quarter (quarter),
        .q_first (q_first)
    );

    assign bit_end     = tick && (quarter == Q3);
    assign sample      = tick && (quarter == Q2);
    assign accept      = bus.cmd_valid && (state == ST_IDLE);
    assign last_byte   = ((byte_cnt + LEN_W'(1)) == len_q);
    assign len_clamped = (bus.cmd_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : bus.cmd_len;
    // First clock of a write byte; the fresh byte drives SDA straight away.
    assign tx_ready_c  = (state == ST_WRITE) && (bit_cnt == 3'd0) && (quarter == Q0) && q_first;
    assign wr_bit      = tx_ready_c ? bus.tx_data[7] : shift[7];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and pad drive for each quarter of the current bit.
    always_comb begin
        state_nxt = state;
        scl_oe_c  = 1'b0;
        sda_oe_c  = 1'b0;
        case (state)
            ST_IDLE: if (bus.cmd_valid) state_nxt = ST_START;
            ST_START: begin
                scl_oe_c = (quarter == Q3);
                sda_oe_c = (quarter == Q2) || (quarter == Q3);
                if (bit_end) state_nxt = ST_ADDR;
            end
            ST_ADDR, ST_WRITE: begin
                scl_oe_c = scl_low(quarter);
                sda_oe_c = ~wr_bit;
                if (bit_end && bit_cnt == LAST_BIT)
                    state_nxt = (state == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
            end
            ST_ADDR_ACK: begin
                scl_oe_c = scl_low(quarter);
                if (bit_end) begin
                    if (ack_q == NACK || len_q == '0) state_nxt = ST_STOP;
                    else                              state_nxt = rw_q ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE_ACK: begin
                scl_oe_c = scl_low(quarter);
                if (bit_end) state_nxt = (ack_q == NACK || last_byte) ? ST_STOP : ST_WRITE;
            end
            ST_READ: begin
                scl_oe_c = scl_low(quarter);
                if (bit_end && bit_cnt == LAST_BIT) state_nxt = ST_READ_ACK;
            end
            ST_READ_ACK: begin
                scl_oe_c = scl_low(quarter);
                sda_oe_c = !last_byte;
                if (bit_end) state_nxt = last_byte ? ST_STOP : ST_READ;
            end
            ST_STOP: begin
                scl_oe_c = (quarter == Q0);
                sda_oe_c = scl_low(quarter);
                if (bit_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Transaction control: counters, captured command, ACK sample, pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            len_q      <= '0;
            rw_q       <= 1'b0;
            ack_q      <= ACK;
            nack_flag  <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            if (accept) begin
                len_q     <= len_clamped;
                rw_q      <= bus.cmd_rw;
                bit_cnt   <= 3'd0;
                byte_cnt  <= '0;
                nack_flag <= 1'b0;
            end
            if (sample) ack_q <= bus.sda_in;
            case (state)
                ST_ADDR, ST_WRITE: if (bit_end) bit_cnt <= bit_cnt + 3'd1;
                ST_READ: if (bit_end) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT) begin
                        rx_data_q  <= shift;
                        rx_valid_q <= 1'b1;
                    end
                end
                ST_ADDR_ACK: if (bit_end && ack_q == NACK) nack_flag <= 1'b1;
                ST_WRITE_ACK: if (bit_end) begin
                    if (ack_q == NACK) nack_flag <= 1'b1;
                    byte_cnt <= byte_cnt + LEN_W'(1);
                end
                ST_READ_ACK: if (bit_end) byte_cnt <= byte_cnt + LEN_W'(1);
                ST_STOP: if (bit_end) begin
                    done_q <= 1'b1;
                    nack_q <= nack_flag;
                end
                default: ;
            endcase
        end
    end

    // Shift register: address/write bits out MSB first, read bits in on SCL high.
    always_ff @(posedge clk) begin
        if (accept)
            shift <= {bus.cmd_addr, bus.cmd_rw};
        else if (tx_ready_c)
            shift <= bus.tx_data;
        else if ((state == ST_ADDR || state == ST_WRITE) && bit_end)
            shift <= {shift[6:0], 1'b0};
        else if (state == ST_READ && sample)
            shift <= {shift[6:0], bus.sda_in};
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.tx_ready  = tx_ready_c;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.done      = done_q;
    assign bus.nack      = nack_q;
    assign bus.scl_oe    = scl_oe_c;
    assign bus.sda_oe    = sda_oe_c;
endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for the burst I2C master: a slave model on the pads, a bus monitor
// decoding SCL/SDA, and a scoreboard of expected per-transaction results.
module tb_i2c_burst_master;
    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 4;
    localparam int LEN_W     = 3;

    typedef struct {
        logic        nack;
        int          lat;
        int          ntx;
        int          nrx;
        int          nbytes;
        logic [39:0] bytes;
        logic [4:0]  acks;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic slave_drive;

    always #5 clk = ~clk;

    i2c_burst_master_if #(.LEN_W(LEN_W)) bus ();

    i2c_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.sda_in = ~(bus.sda_oe | slave_drive);

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   accept_cyc = 0;
    int   tx_cnt, rx_cnt, stop_cnt, nb;
    bit   done_seen;
    logic cap [0:63];
    logic prev_scl, prev_sda;

    exp_t       done_q [$];
    logic [7:0] rx_q   [$];
    logic [7:0] tx_src [$];

    logic        slv_ack_addr;
    logic        slv_read;
    int          slv_nbytes;
    logic [31:0] slv_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic nk, input int lat, input int ntx, input int nrx,
                                input int nbytes, input logic [39:0] bytes, input logic [4:0] acks);
        exp_t e;
        e.nack = nk; e.lat = lat; e.ntx = ntx; e.nrx = nrx;
        e.nbytes = nbytes; e.bytes = bytes; e.acks = acks;
        return e;
    endfunction

    // Slave pull-down for line bit index n counted from START.
    function automatic logic slave_bit(input int n);
        int k, j;
        if (n < 8)  return 1'b0;
        if (n == 8) return slv_ack_addr;
        k = (n - 9) / 9;
        j = (n - 9) % 9;
        if (k >= slv_nbytes) return 1'b0;
        if (slv_read) return (j < 8) ? !slv_rd[8*k + 7 - j] : 1'b0;
        return (j == 8);
    endfunction

    // Bus monitor, slave model, tx feeder and scoreboard checker.
    always @(negedge clk) begin
        logic scl, sda;
        exp_t e;
        logic [7:0] got;
        scl = !bus.scl_oe;
        sda = !(bus.sda_oe | slave_drive);
        if (reset) begin
            slave_drive = 1'b0;
            nb = -1;
            prev_scl = 1'b1;
            prev_sda = 1'b1;
        end else begin
            if (prev_scl && scl && prev_sda && !sda) nb = -1;
            if (prev_scl && scl && !prev_sda && sda) stop_cnt++;
            if (!prev_scl && scl && nb >= 0 && nb < 64) cap[nb] = sda;
            if (prev_scl && !scl) begin
                nb++;
                slave_drive = slave_bit(nb);
            end
            if (bus.tx_ready) begin
                tx_cnt++;
                bus.tx_data = (tx_src.size() > 0) ? tx_src.pop_front() : 8'h00;
            end
            if (bus.rx_valid) begin
                rx_cnt++;
                if (rx_q.size() == 0) check("rx_unexpected", 32'(bus.rx_data), 32'hFFFF);
                else                  check("rx_data", 32'(bus.rx_data), 32'(rx_q.pop_front()));
            end
            if (bus.done) begin
                done_seen = 1'b1;
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(bus.done), 32'd0);
                end else begin
                    e = done_q.pop_front();
                    check("nack", 32'(bus.nack), 32'(e.nack));
                    check("latency", 32'(cyc - accept_cyc), 32'(e.lat));
                    check("tx_ready_count", 32'(tx_cnt), 32'(e.ntx));
                    check("rx_valid_count", 32'(rx_cnt), 32'(e.nrx));
                    check("stop_seen", 32'(stop_cnt), 32'd1);
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                    for (int k = 0; k < e.nbytes; k++) begin
                        for (int b = 0; b < 8; b++) got[7-b] = cap[9*k + b];
                        check($sformatf("sda_byte%0d", k), 32'(got), 32'(e.bytes[8*k +: 8]));
                        check($sformatf("ack_bit%0d", k), 32'(cap[9*k + 8]), 32'(e.acks[k]));
                    end
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    task automatic issue(input logic [6:0] a, input logic rw, input int len);
        @(negedge clk);
        tx_cnt = 0; rx_cnt = 0; stop_cnt = 0; done_seen = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_rw    = rw;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc    = cyc;
        bus.cmd_valid = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("ready_after_accept", 32'(bus.cmd_ready), 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done_seen; i++) @(negedge clk);
        check("done_within_budget", 32'(done_seen), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int toggles;
        logic ps, pc;
        reset = 1'b1;
        slave_drive = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = 7'h00; bus.cmd_rw = 1'b0;
        bus.cmd_len = '0; bus.tx_data = 8'h00;
        slv_ack_addr = 1'b1; slv_read = 1'b0; slv_nbytes = 0; slv_rd = 32'h0;
        tx_cnt = 0; rx_cnt = 0; stop_cnt = 0; nb = -1; done_seen = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_outputs", {24'h0, bus.busy, bus.done, bus.nack, bus.tx_ready,
                              bus.rx_valid, bus.scl_oe, bus.sda_oe, 1'b0}, 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Burst write, slave ACKs everything.
        slv_ack_addr = 1'b1; slv_read = 1'b0; slv_nbytes = 2;
        tx_src.push_back(8'hA5); tx_src.push_back(8'h3C);
        done_q.push_back(mk(1'b0, 464, 2, 0, 3, 40'h00_003C_A5A0, 5'b00000));
        issue(7'h50, 1'b0, 2);
        repeat (8) @(negedge clk);
        check("start_sda_before", 32'(bus.sda_oe), 32'd0);
        @(negedge clk);
        check("start_sda_fall", 32'(bus.sda_oe), 32'd1);
        check("start_scl_high", 32'(bus.scl_oe), 32'd0);
        wait_done();

        // Address NACK aborts before any data byte.
        slv_ack_addr = 1'b0; slv_read = 1'b0; slv_nbytes = 3;
        done_q.push_back(mk(1'b1, 176, 0, 0, 1, 40'h44, 5'b00001));
        issue(7'h22, 1'b0, 3);
        wait_done();

        // Burst read: master ACKs byte 1, NACKs the last byte.
        slv_ack_addr = 1'b1; slv_read = 1'b1; slv_nbytes = 2; slv_rd = 32'h0000_7EC3;
        rx_q.push_back(8'hC3); rx_q.push_back(8'h7E);
        done_q.push_back(mk(1'b0, 464, 0, 2, 3, 40'h00_007E_C3D1, 5'b00100));
        issue(7'h68, 1'b1, 2);
        wait_done();

        // Address-only probe.
        slv_ack_addr = 1'b1; slv_read = 1'b0; slv_nbytes = 0;
        done_q.push_back(mk(1'b0, 176, 0, 0, 1, 40'h78, 5'b00000));
        issue(7'h3C, 1'b0, 0);
        wait_done();

        // Oversized length is clamped to MAX_BYTES.
        slv_ack_addr = 1'b1; slv_read = 1'b0; slv_nbytes = 4;
        tx_src.push_back(8'h11); tx_src.push_back(8'h22);
        tx_src.push_back(8'h33); tx_src.push_back(8'h44);
        done_q.push_back(mk(1'b0, 752, 4, 0, 5, 40'h44_3322_11A0, 5'b00000));
        issue(7'h50, 1'b0, 7);
        wait_done();

        // Reset in the middle of a write byte.
        slv_ack_addr = 1'b1; slv_read = 1'b0; slv_nbytes = 1;
        tx_src.push_back(8'h96);
        issue(7'h50, 1'b0, 1);
        for (int i = 0; i < 1000 && tx_cnt == 0; i++) @(negedge clk);
        check("midreset_tx_ready_seen", 32'(tx_cnt), 32'd1);
        repeat (3 * 16 + 5) @(negedge clk);
        check("midreset_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_oe", {30'h0, bus.scl_oe, bus.sda_oe}, 32'd0);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_ready", 32'(bus.cmd_ready), 32'd1);
        reset = 1'b0;
        toggles = 0;
        ps = bus.sda_oe; pc = bus.scl_oe;
        repeat (1000) begin
            @(negedge clk);
            if (bus.sda_oe !== ps || bus.scl_oe !== pc) toggles++;
            ps = bus.sda_oe; pc = bus.scl_oe;
        end
        check("idle_oe_toggles", 32'(toggles), 32'd0);
        check("idle_done_count", 32'(done_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
